// File: rtl/led_pkg.sv
// Shared constants for the 4-digit LED driver: active-low segment patterns
// ({a,b,c,d,e,f,g}) for hex digits and the scan phase encodings.
package led_pkg;

    localparam logic [1:0] PH_LOAD  = 2'b11;
    localparam logic [1:0] PH_BLANK = 2'b00;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    function automatic logic [6:0] hex2seg(input logic [3:0] hex);
        case (hex)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/led_decoder.sv
// Combinational hex -> active-low 7-segment decoder.
module led_decoder
    import led_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = hex2seg(hex);

endmodule

// File: rtl/four_digit_led_driver.sv
// Time-multiplexed 4-digit common-anode driver: each digit slot is
// LOAD, ON, ON, BLANK; outputs are registered and follow the new scan state.
module four_digit_led_driver
    import led_pkg::*;
#(
    parameter int          DIV_RATIO = 16,
    parameter logic [15:0] MESSAGE   = 16'h0123
) (
    input  logic clk,
    input  logic reset,
    output logic an3,
    output logic an2,
    output logic an1,
    output logic an0,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g,
    output logic dp
);

    localparam int DW = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;

    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    st, st_nx;
    logic [3:0]    an_r, an_nx;
    logic [6:0]    seg_r, seg_dec;
    logic [3:0]    nib;

    assign tick  = (div_cnt == DW'(DIV_RATIO - 1));
    assign st_nx = st - 4'd1;
    // Digit nibble for the slot the counter is about to enter.
    assign nib   = MESSAGE[{st_nx[3:2], 2'b00} +: 4];

    led_decoder u_dec (
        .hex (nib),
        .seg (seg_dec)
    );

    always_comb begin
        an_nx = 4'hF;
        if (st_nx[1:0] != PH_LOAD && st_nx[1:0] != PH_BLANK)
            an_nx[st_nx[3:2]] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            st      <= 4'hF;
            an_r    <= 4'hF;
            seg_r   <= hex2seg(MESSAGE[15:12]);
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            if (tick) begin
                st   <= st_nx;
                an_r <= an_nx;
                if (st_nx[1:0] == PH_LOAD)
                    seg_r <= seg_dec;
            end
        end
    end

    assign {an3, an2, an1, an0}   = an_r;
    assign {a, b, c, d, e, f, g}  = seg_r;
    assign dp                     = 1'b1;

endmodule

// File: tb/tb_four_digit_led_driver.sv
// Bench: four drivers with different messages (covering all 16 hex codes)
// run side by side under random reset/run lengths against a tick-count model.
module tb_four_digit_led_driver;

    localparam int DIV = 4;
    localparam int N   = 4;
    localparam logic [15:0] MSG [N] = '{16'h0123, 16'h89AF, 16'h4567, 16'hBCDE};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] an  [N];
    logic [6:0] seg [N];
    logic       dp  [N];

    int checks = 0;
    int errors = 0;
    int n = 0;

    logic [6:0] tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    always #5 clk = ~clk;

    four_digit_led_driver #(.DIV_RATIO(DIV), .MESSAGE(MSG[0])) dut0 (
        .clk(clk), .reset(rst), .an3(an[0][3]), .an2(an[0][2]), .an1(an[0][1]), .an0(an[0][0]),
        .a(seg[0][6]), .b(seg[0][5]), .c(seg[0][4]), .d(seg[0][3]), .e(seg[0][2]), .f(seg[0][1]),
        .g(seg[0][0]), .dp(dp[0]));
    four_digit_led_driver #(.DIV_RATIO(DIV), .MESSAGE(MSG[1])) dut1 (
        .clk(clk), .reset(rst), .an3(an[1][3]), .an2(an[1][2]), .an1(an[1][1]), .an0(an[1][0]),
        .a(seg[1][6]), .b(seg[1][5]), .c(seg[1][4]), .d(seg[1][3]), .e(seg[1][2]), .f(seg[1][1]),
        .g(seg[1][0]), .dp(dp[1]));
    four_digit_led_driver #(.DIV_RATIO(DIV), .MESSAGE(MSG[2])) dut2 (
        .clk(clk), .reset(rst), .an3(an[2][3]), .an2(an[2][2]), .an1(an[2][1]), .an0(an[2][0]),
        .a(seg[2][6]), .b(seg[2][5]), .c(seg[2][4]), .d(seg[2][3]), .e(seg[2][2]), .f(seg[2][1]),
        .g(seg[2][0]), .dp(dp[2]));
    four_digit_led_driver #(.DIV_RATIO(DIV), .MESSAGE(MSG[3])) dut3 (
        .clk(clk), .reset(rst), .an3(an[3][3]), .an2(an[3][2]), .an1(an[3][1]), .an0(an[3][0]),
        .a(seg[3][6]), .b(seg[3][5]), .c(seg[3][4]), .d(seg[3][3]), .e(seg[3][2]), .f(seg[3][1]),
        .g(seg[3][0]), .dp(dp[3]));

    // Model: tick index since reset release picks the slot; within each
    // 4-tick slot the digit is loaded, lit for two ticks, then blanked.
    function automatic logic [3:0] exp_an(input int cyc);
        int pos, digit, ph;
        pos   = (cyc / DIV) % 16;
        digit = 3 - pos / 4;
        ph    = pos % 4;
        return (ph == 1 || ph == 2) ? ~(4'b0001 << digit) : 4'hF;
    endfunction

    function automatic logic [6:0] exp_seg(input int cyc, input logic [15:0] msg);
        int digit;
        logic [15:0] m;
        digit = 3 - ((cyc / DIV) % 16) / 4;
        m = msg >> (4 * digit);
        return tbl[m[3:0]];
    endfunction

    task automatic chk(input string tag, input int idx, input logic [6:0] obs, input logic [6:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s dut%0d n=%0d observed=%b expected=%b", tag, idx, n, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            chk({tag, "_an"}, i, {3'b000, an[i]}, {3'b000, exp_an(n)});
            chk({tag, "_seg"}, i, seg[i], exp_seg(n, MSG[i]));
            chk({tag, "_dp"}, i, {6'd0, dp[i]}, 7'd1);
            chk({tag, "_onehot"}, i, {6'd0, ($countones(~an[i]) <= 1)}, 7'd1);
        end
    endtask

    task automatic run(input int cycles, input string tag);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            if (!rst) n++;
            @(negedge clk);
            check_all(tag);
        end
    endtask

    // Assert reset mid-cycle and check before the next clock edge.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        n = 0;
        #1 check_all(tag);
    endtask

    initial begin
        #10;
        @(negedge clk);
        n = 0;
        check_all("reset");
        rst = 1'b0;
        run(128, "two_refresh");
        // Land inside an1's lit window (ticks 9,10 -> cycles 36..43).
        async_reset("pre_an1");
        run(1, "rst_hold");
        rst = 1'b0;
        run(38, "to_an1");
        for (int i = 0; i < N; i++)
            chk("an1_lit", i, {3'b000, an[i]}, 7'b0001101);
        async_reset("async_an1");
        run(2, "rst_hold");
        rst = 1'b0;
        run(70, "restart");
        for (int s = 0; s < 12; s++) begin
            async_reset("async_rand");
            run($urandom_range(1, 3), "rst_rand");
            rst = 1'b0;
            run($urandom_range(5, 150), "run_rand");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
